// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receive path.
// Samples the asynchronous rx line at mid-bit, assembles bytes LSB first and
// presents them on a valid/ack register. Flags framing errors (one-cycle pulse)
// and overruns (sticky until reset). Bit timing is CLK_CYCLES clocks per bit.
// Optional feature: define UART_RX_MAJORITY_EN for 3-sample majority voting
// on the synchronised line (rejects single-cycle glitches at the sample point).
module uart_receiver #(
    parameter int CLK_CYCLES = 4167,
    parameter int CTR_WIDTH  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int HALF = CLK_CYCLES / 2;
    localparam logic [CTR_WIDTH-1:0] HALF_M1 = CTR_WIDTH'(HALF - 1);
    localparam logic [CTR_WIDTH-1:0] FULL_M1 = CTR_WIDTH'(CLK_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic                 rx_meta;
    logic                 rx_s;
    logic                 samp;
    logic                 start_det;

    logic [CTR_WIDTH-1:0] ctr;
    logic [2:0]           bit_idx;
    logic [7:0]           shreg;

    logic                 ctr_clr;
    logic                 shift_en;
    logic                 stop_hit;
    logic                 deliver;
    logic                 bad_stop;

    // Two-flop synchroniser for the asynchronous line; idles high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [2:0] hist;

    // History of the synchronised line, shifted every clock, for majority voting.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist <= '1;
        end else begin
            hist <= {hist[1:0], rx_s};
        end
    end

    assign samp = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
    // Start detection taps the history so the whole frame is timed one clock
    // later, keeping the voting window near the middle of each bit.
    assign start_det = ~hist[0];
`else
    assign samp      = rx_s;
    assign start_det = ~rx_s;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_det) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (ctr == HALF_M1) begin
                    // A high sample mid-start-bit is a glitch: drop back silently.
                    state_nxt = samp ? IDLE : DATA;
                end
            end
            DATA: begin
                if ((ctr == FULL_M1) && (bit_idx == 3'd7)) begin
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (ctr == FULL_M1) begin
                    state_nxt = samp ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                // Break condition: no new frame until the line returns high.
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output / control decode from the state register and counter.
    always_comb begin
        busy     = (state != IDLE);
        shift_en = (state == DATA) && (ctr == FULL_M1);
        stop_hit = (state == STOP) && (ctr == FULL_M1);
        deliver  = stop_hit && samp;
        bad_stop = stop_hit && !samp;
        // Counter restarts on every compare match and on every state change,
        // and is held at zero in the states that do not time anything.
        ctr_clr  = (state == IDLE) || (state == WAIT_HIGH) ||
                   (state_nxt != state) || shift_en;
    end

    // Bit-period counter, bit index and receive shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctr     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (ctr_clr) begin
                ctr <= '0;
            end else begin
                ctr <= ctr + 1'b1;
            end
            if (state == START) begin
                bit_idx <= '0;
            end else if (shift_en) begin
                bit_idx <= bit_idx + 1'b1;
            end
            if (shift_en) begin
                shreg <= {samp, shreg[7:1]};
            end
        end
    end

    // Consumer handshake: delivery, ack, overrun and framing-error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (deliver) begin
                if (!valid || ack) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule
